// File: rtl/mano_ctrl_pkg.sv
// Shared types and constants for the MANO instruction-cycle sequencer.
package mano_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      INDIRECT  = 3'd3,
      EXECUTE   = 3'd4,
      INTERRUPT = 3'd5,
      HALT      = 3'd6
   } state_t;

   // Timing indices of the fixed instruction-cycle phases
   localparam int T_FETCH0 = 0;
   localparam int T_FETCH1 = 1;
   localparam int T_DECODE = 2;
   localparam int T_IND    = 3;

   // D7 selects register-reference / I/O instructions
   localparam int D_IO_REG = 7;

   // HLT is the register-reference instruction with IR[0] set
   function automatic logic is_hlt(input logic [7:0] d_op, input logic ir_i, input logic ir_hlt);
      return d_op[D_IO_REG] & ~ir_i & ir_hlt;
   endfunction

endpackage

// File: rtl/mano_seq_cnt.sv
// Sequence counter SC with clear/increment and one-hot T decode.
module mano_seq_cnt #(
   parameter int SC_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  inc,
   output logic [SC_W-1:0]       sc,
   output logic [(1<<SC_W)-1:0]  t
);

   logic [SC_W-1:0] sc_q;
   logic [SC_W-1:0] sc_d;

   // Next count: clear has priority over increment
   always_comb begin
      sc_d = sc_q;
      if (clr) begin
         sc_d = {SC_W{1'b0}};
      end else if (inc) begin
         sc_d = sc_q + SC_W'(1);
      end else begin
         sc_d = sc_q;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc_q <= {SC_W{1'b0}};
      end else begin
         sc_q <= sc_d;
      end
   end

   // One-hot decode of the current count
   always_comb begin
      t       = {(1<<SC_W){1'b0}};
      t[sc_q] = 1'b1;
   end

   assign sc = sc_q;

endmodule

// File: rtl/mano_seq_ctrl_chk.sv
// Assertion checker for the sequencer's interface invariants.
module mano_seq_ctrl_chk (
   input logic        clk,
   input logic        rst_n,
   input logic [15:0] t,
   input logic        ar_ld_ir,
   input logic [7:0]  d_op
);

   // Timing signals are always the one-hot decode of SC
   a_t_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(t))
      else $error("t not one-hot: %h", t);

   // The opcode decoder must present a one-hot D vector while decoding
   a_dop_onehot: assert property (@(posedge clk) disable iff (!rst_n) ar_ld_ir |-> $onehot(d_op))
      else $error("d_op not one-hot in decode: %b", d_op);

endmodule

// File: rtl/mano_seq_ctrl.sv
// MANO instruction-cycle sequencer: SC/T timing, R flip-flop and micro-op strobes.
module mano_seq_ctrl
   import mano_ctrl_pkg::*;
#(
   parameter int SC_W     = 4,
   parameter int EXEC_MAX = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic                  ir_i,
   input  logic [7:0]            d_op,
   input  logic                  ir_hlt,
   input  logic                  ien,
   input  logic                  fgi,
   input  logic                  fgo,
   input  logic                  exec_done,
   output logic [(1<<SC_W)-1:0]  t,
   output logic                  ar_ld_pc,
   output logic                  ir_ld_mem,
   output logic                  pc_inc,
   output logic                  ar_ld_ir,
   output logic                  ar_ld_mem,
   output logic                  int_save,
   output logic                  int_wr,
   output logic                  ien_clr,
   output logic                  exec_en,
   output logic                  r_flag,
   output logic                  halted,
   output logic                  fault
);

   state_t          state_q, state_d;
   logic            r_flag_q, r_flag_d;
   logic            halted_q, halted_d;
   logic            fault_q, fault_d;
   logic            sc_clr_s, sc_inc_s;
   logic            r_set_s, r_clr_s;
   logic [SC_W-1:0] sc_s;
   logic [(1<<SC_W)-1:0] t_s;
   state_t          fetch_tgt_s;

   mano_seq_cnt #(.SC_W(SC_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (sc_clr_s),
      .inc   (sc_inc_s),
      .sc    (sc_s),
      .t     (t_s)
   );

   // R flip-flop next value: set by a pending interrupt outside T0..T2, cleared at end of interrupt cycle
   always_comb begin
      r_set_s = 1'b0;
      r_clr_s = 1'b0;
      if ((state_q == FETCH) || (state_q == DECODE) || (state_q == INDIRECT) || (state_q == EXECUTE)) begin
         r_set_s = ~t_s[0] & ~t_s[1] & ~t_s[2] & ~r_flag_q & ien & (fgi | fgo);
      end else begin
         r_set_s = 1'b0;
      end
      if ((state_q == INTERRUPT) && t_s[2]) begin
         r_clr_s = 1'b1;
      end else begin
         r_clr_s = 1'b0;
      end
      if (r_set_s) begin
         r_flag_d = 1'b1;
      end else if (r_clr_s) begin
         r_flag_d = 1'b0;
      end else begin
         r_flag_d = r_flag_q;
      end
      // A new instruction cycle becomes an interrupt cycle whenever R will be set
      if (r_flag_d) begin
         fetch_tgt_s = INTERRUPT;
      end else begin
         fetch_tgt_s = FETCH;
      end
   end

   // Next-state, counter control and status flags
   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      fault_d  = fault_q;
      sc_clr_s = 1'b0;
      sc_inc_s = 1'b0;
      case (state_q)
         IDLE: begin
            sc_clr_s = 1'b1;
            if (run) begin
               state_d = fetch_tgt_s;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            sc_inc_s = 1'b1;
            if (t_s[T_FETCH1]) begin
               state_d = DECODE;
            end else begin
               state_d = FETCH;
            end
         end
         DECODE: begin
            if (is_hlt(d_op, ir_i, ir_hlt)) begin
               state_d  = HALT;
               sc_clr_s = 1'b1;
               halted_d = 1'b1;
            end else if (ir_i && !d_op[D_IO_REG]) begin
               state_d  = INDIRECT;
               sc_inc_s = 1'b1;
            end else begin
               state_d  = EXECUTE;
               sc_inc_s = 1'b1;
            end
         end
         INDIRECT: begin
            state_d  = EXECUTE;
            sc_inc_s = 1'b1;
         end
         EXECUTE: begin
            if (exec_done) begin
               state_d  = fetch_tgt_s;
               sc_clr_s = 1'b1;
            end else if (sc_s == SC_W'(EXEC_MAX)) begin
               state_d  = HALT;
               sc_clr_s = 1'b1;
               fault_d  = 1'b1;
            end else begin
               sc_inc_s = 1'b1;
            end
         end
         INTERRUPT: begin
            if (t_s[2]) begin
               state_d  = FETCH;
               sc_clr_s = 1'b1;
            end else begin
               sc_inc_s = 1'b1;
            end
         end
         HALT: begin
            sc_clr_s = 1'b1;
            if (run) begin
               state_d  = fetch_tgt_s;
               halted_d = 1'b0;
            end else begin
               state_d  = HALT;
            end
         end
         default: begin
            state_d  = IDLE;
            sc_clr_s = 1'b1;
         end
      endcase
   end

   // Control state and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         r_flag_q <= 1'b0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         r_flag_q <= r_flag_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
      end
   end

   // Micro-op strobes are decoded from state and T in the same cycle
   assign ar_ld_pc  = (state_q == FETCH)     & t_s[T_FETCH0];
   assign ir_ld_mem = (state_q == FETCH)     & t_s[T_FETCH1];
   assign pc_inc    = ((state_q == FETCH)    & t_s[T_FETCH1]) |
                      ((state_q == INTERRUPT) & t_s[2]);
   assign ar_ld_ir  = (state_q == DECODE)    & t_s[T_DECODE];
   assign ar_ld_mem = (state_q == INDIRECT)  & t_s[T_IND];
   assign int_save  = (state_q == INTERRUPT) & t_s[0];
   assign int_wr    = (state_q == INTERRUPT) & t_s[1];
   assign ien_clr   = (state_q == INTERRUPT) & t_s[2];
   assign exec_en   = (state_q == EXECUTE);
   assign t         = t_s;
   assign r_flag    = r_flag_q;
   assign halted    = halted_q;
   assign fault     = fault_q;

endmodule

// File: doc/mano_seq_ctrl.md
Name: mano_seq_ctrl

Overview:
- Instruction-cycle sequencer for the MANO computer.
- Owns the 4-bit sequence counter (SC), the T0..T15 timing decode and the R (interrupt-cycle) flip-flop.
- Walks fetch, decode, indirect, execute and interrupt phases, emitting one-cycle micro-op strobes to the register/memory datapath.
- Consumes the latched opcode one-hot D0..D7 from the existing 3-to-8 opcode decoder; hands control to the datapath during execute until it reports completion.

Parameters:
- SC_W, 4, sequence counter width (T0..T(2^SC_W-1)).
- EXEC_MAX, 15, last legal T index in execute; reaching it without exec_done is a fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/resume pulse; leaves IDLE or HALT.
- ir_i  in  1  IR[15], indirect bit.
- d_op  in  8  one-hot opcode D0..D7 from opcode decoder (IR[14:12]).
- ir_hlt  in  1  IR[0]; HLT when D7 & ~ir_i.
- ien  in  1  interrupt enable flip-flop.
- fgi  in  1  input flag.
- fgo  in  1  output flag.
- exec_done  in  1  datapath finished execute; clears SC.
- t  out  16  one-hot timing signals T0..T15.
- ar_ld_pc  out  1  AR<-PC.
- ir_ld_mem  out  1  IR<-M[AR].
- pc_inc  out  1  PC<-PC+1.
- ar_ld_ir  out  1  AR<-IR[11:0].
- ar_ld_mem  out  1  AR<-M[AR] (indirect).
- int_save  out  1  AR<-0, TR<-PC.
- int_wr  out  1  M[AR]<-TR, PC<-0.
- ien_clr  out  1  IEN<-0.
- exec_en  out  1  execute phase active.
- r_flag  out  1  R flip-flop.
- halted  out  1  HLT executed.
- fault  out  1  execute overran EXEC_MAX; sticky until reset.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, SC=0, r_flag=0, halted=0, fault=0.
  - t=16'h0001, all strobes 0.
  - Reset mid-instruction aborts immediately with no partial strobes.
- t is always the one-hot decode of SC. Strobes are combinational from state and SC, valid in the same cycle as their T.
- IDLE: SC held 0. run=1 moves to FETCH next edge.
- FETCH, r_flag=0:
  - T0: ar_ld_pc.
  - T1: ir_ld_mem, pc_inc.
  - SC increments each edge.
- FETCH, r_flag=1: INTERRUPT instead.
  - T0: int_save.
  - T1: int_wr.
  - T2: pc_inc, ien_clr; r_flag<=0, SC<=0, back to FETCH.
- DECODE (T2, r_flag=0):
  - ar_ld_ir asserted.
  - Next state is INDIRECT if ir_i & ~d_op[7], otherwise EXECUTE.
  - HLT (d_op[7] & ~ir_i & ir_hlt): go to HALT, SC<=0, halted<=1.
- INDIRECT (T3): ar_ld_mem, then EXECUTE.
- EXECUTE (T3 or T4 onward):
  - exec_en=1 and SC counts up.
  - exec_done=1 gives SC<=0 and FETCH next edge.
  - SC==EXEC_MAX with no exec_done sets fault, SC<=0, state HALT.
- HALT:
  - SC held 0, exec_en=0.
  - run=1 clears halted and goes to FETCH (fault stays set).
- R set rule:
  - When state is FETCH/DECODE/INDIRECT/EXECUTE, t[0],t[1],t[2] are all 0, r_flag=0 and ien & (fgi|fgo), set r_flag next edge.
  - Never set during INTERRUPT, IDLE or HALT.
- Simultaneous events:
  - exec_done together with an R-set condition: both apply. SC clears, r_flag sets, and the next FETCH is an interrupt cycle.
  - exec_done at SC==EXEC_MAX counts as completion, no fault.
  - run while running is ignored.
- d_op not one-hot (including all zero) in DECODE: treated as memory-reference per ir_i with no special case; the assertion checker flags it.
- SC wrap: SC never wraps; leaving EXECUTE always clears it.

Decomposition:
- Package mano_ctrl_pkg holds:
  - State enum {IDLE, FETCH, DECODE, INDIRECT, EXECUTE, INTERRUPT, HALT}.
  - Constants T_FETCH0=0, T_FETCH1=1, T_DECODE=2, T_IND=3.
  - Opcode index D_IO_REG=7.
- One sub-module, mano_seq_cnt: SC register with clr/inc inputs and 4-to-16 one-hot decode to t.

Test Plan:
- Direct AND (d_op=8'h01, ir_i=0), exec_done at T5:
  - ar_ld_pc@T0, ir_ld_mem+pc_inc@T1, ar_ld_ir@T2.
  - exec_en T3..T5, no ar_ld_mem.
  - t=0x0001 on the next cycle.
- Indirect LDA (d_op=8'h04, ir_i=1): ar_ld_mem exactly at T3, exec_en from T4, exec_done@T4 returns to T0.
- HLT (d_op=8'h80, ir_i=0, ir_hlt=1):
  - halted=1 after T2, t stays 0x0001, no strobes.
  - run pulse resumes fetch with halted=0.
- ien=1, fgi=1 during execute T3:
  - r_flag=1 next cycle.
  - After exec_done: int_save@T0, int_wr@T1, pc_inc+ien_clr@T2, then r_flag=0 and normal fetch.
- exec_done withheld:
  - fault=1 and HALT at T15, SC=0.
  - Assert rst_n=0 mid-T1 of a later fetch: all outputs return to reset values asynchronously.
